// File: rtl/hilo_acc.sv
`default_nettype none
// ============================================================================
// Module   : hilo_acc
// Purpose  : HI/LO special registers with partial writes, clear and
//            2*WIDTH-bit multiply-accumulate / multiply-subtract.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_acc #(
    parameter int WIDTH     = 32,
    parameter int SPLIT_ACC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy,
    output logic             done
);
    localparam logic [2:0] c_op_write    = 3'b001;
    localparam logic [2:0] c_op_write_hi = 3'b010;
    localparam logic [2:0] c_op_write_lo = 3'b011;
    localparam logic [2:0] c_op_madd     = 3'b100;
    localparam logic [2:0] c_op_msub     = 3'b101;
    localparam logic [2:0] c_op_clear    = 3'b110;
    localparam bit         c_split       = (SPLIT_ACC != 0);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACC_HI = 1'b1
    } state_t;

    state_t             r_state, w_state_next;
    logic [WIDTH-1:0]   r_hi, r_lo, r_hi_op;
    logic [WIDTH-1:0]   w_hi_next, w_lo_next, w_hi_op_next;
    logic               r_carry, w_carry_next;
    logic               r_done, w_done_next;
    logic               w_accept, w_sub;
    logic [WIDTH-1:0]   w_hi_addend, w_lo_addend;
    logic [WIDTH:0]     w_lo_sum;
    logic [WIDTH-1:0]   w_hi_sum;
    logic [2*WIDTH-1:0] w_full_sum;

    assign w_accept = req_valid && req_ready;
    assign w_sub    = (op == c_op_msub);

    // Subtraction is addition of the one's complement with carry-in 1.
    assign w_hi_addend = w_sub ? ~hi_i : hi_i;
    assign w_lo_addend = w_sub ? ~lo_i : lo_i;
    assign w_lo_sum    = {1'b0, r_lo} + {1'b0, w_lo_addend} + {{WIDTH{1'b0}}, w_sub};
    assign w_hi_sum    = r_hi + r_hi_op + {{(WIDTH-1){1'b0}}, r_carry};
    assign w_full_sum  = {r_hi, r_lo} + {w_hi_addend, w_lo_addend}
                       + {{(2*WIDTH-1){1'b0}}, w_sub};

    generate
        if (SPLIT_ACC != 0) begin : g_split
            assign busy = (r_state == ST_ACC_HI);
        end else begin : g_single
            assign busy = 1'b0;
        end
    endgenerate

    assign req_ready = !busy;
    assign hi_o      = r_hi;
    assign lo_o      = r_lo;
    assign done      = r_done;

    always_comb begin
        w_state_next = r_state;
        w_hi_next    = r_hi;
        w_lo_next    = r_lo;
        w_hi_op_next = r_hi_op;
        w_carry_next = r_carry;
        w_done_next  = 1'b0;
        case (r_state)
            ST_ACC_HI: begin
                w_hi_next    = w_hi_sum;
                w_done_next  = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                if (w_accept) begin
                    case (op)
                        c_op_write: begin
                            w_hi_next   = hi_i;
                            w_lo_next   = lo_i;
                            w_done_next = 1'b1;
                        end
                        c_op_write_hi: begin
                            w_hi_next   = hi_i;
                            w_done_next = 1'b1;
                        end
                        c_op_write_lo: begin
                            w_lo_next   = lo_i;
                            w_done_next = 1'b1;
                        end
                        c_op_clear: begin
                            w_hi_next   = '0;
                            w_lo_next   = '0;
                            w_done_next = 1'b1;
                        end
                        c_op_madd, c_op_msub: begin
                            if (c_split) begin
                                // LO half now; HI half next edge with the stored carry.
                                w_lo_next    = w_lo_sum[WIDTH-1:0];
                                w_carry_next = w_lo_sum[WIDTH];
                                w_hi_op_next = w_hi_addend;
                                w_state_next = ST_ACC_HI;
                            end else begin
                                w_hi_next   = w_full_sum[2*WIDTH-1:WIDTH];
                                w_lo_next   = w_full_sum[WIDTH-1:0];
                                w_done_next = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_hi    <= '0;
            r_lo    <= '0;
            r_hi_op <= '0;
            r_carry <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_hi    <= w_hi_next;
            r_lo    <= w_lo_next;
            r_hi_op <= w_hi_op_next;
            r_carry <= w_carry_next;
            r_done  <= w_done_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hilo_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_acc
// Purpose  : Scoreboard bench for hilo_acc, split and single-cycle variants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hilo_acc;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    int               cyc = 0;
    int               checks = 0;
    int               errors = 0;

    // Split-accumulate instance
    logic             v1 = 1'b0;
    logic [2:0]       op1 = 3'b000;
    logic [WIDTH-1:0] hi1_i = '0, lo1_i = '0;
    logic [WIDTH-1:0] hi1_o, lo1_o;
    logic             rdy1, busy1, done1;

    // Single-cycle instance
    logic             v0 = 1'b0;
    logic [2:0]       op0 = 3'b000;
    logic [WIDTH-1:0] hi0_i = '0, lo0_i = '0;
    logic [WIDTH-1:0] hi0_o, lo0_o;
    logic             rdy0, busy0, done0;

    logic [2*WIDTH-1:0] q1[$];
    logic [2*WIDTH-1:0] q0[$];

    hilo_acc #(.WIDTH(WIDTH), .SPLIT_ACC(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .op(op1),
        .hi_i(hi1_i), .lo_i(lo1_i), .hi_o(hi1_o), .lo_o(lo1_o),
        .busy(busy1), .done(done1)
    );

    hilo_acc #(.WIDTH(WIDTH), .SPLIT_ACC(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .op(op0),
        .hi_i(hi0_i), .lo_i(lo0_i), .hi_o(hi0_o), .lo_o(lo0_o),
        .busy(busy0), .done(done0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: every done pulse pops one expected {hi,lo}.
    always @(negedge clk) begin
        if (!rst) begin
            if (done1) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done1_unexpected: got done with {%h,%h} expected no done", hi1_o, lo1_o);
                end else begin
                    check("split_result", {hi1_o, lo1_o}, q1.pop_front());
                end
            end
            if (done0) begin
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done0_unexpected: got done with {%h,%h} expected no done", hi0_o, lo0_o);
                end else begin
                    check("single_result", {hi0_o, lo0_o}, q0.pop_front());
                end
            end
            check("single_busy", {63'd0, busy0}, 64'd0);
        end
    end

    // Issue one request on the split instance, holding it while not ready.
    task automatic send1(input logic [2:0] op, input logic [31:0] h, input logic [31:0] l,
                         input bit push, input logic [31:0] eh, input logic [31:0] el,
                         output int acc_cyc);
        int n;
        if (push) q1.push_back({eh, el});
        v1 = 1'b1; op1 = op; hi1_i = h; lo1_i = l;
        n = 0;
        while (!rdy1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10) begin
            checks++; errors++;
            $display("FAIL ready_timeout: got req_ready=0 expected 1 within 10 cycles");
        end
        @(posedge clk);
        acc_cyc = cyc;
        #1;
        v1 = 1'b0; op1 = 3'b000;
    endtask

    task automatic send0(input logic [2:0] op, input logic [31:0] h, input logic [31:0] l,
                         input logic [31:0] eh, input logic [31:0] el);
        q0.push_back({eh, el});
        v0 = 1'b1; op0 = op; hi0_i = h; lo0_i = l;
        @(posedge clk);
        #1;
        v0 = 1'b0; op0 = 3'b000;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200us");
        $fatal(1, "timeout");
    end

    initial begin
        int ka, kb;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_hilo", {hi1_o, lo1_o}, 64'd0);
        check("reset_flags", {60'd0, busy1, done1, rdy1, rdy0}, 64'h3);

        // Partial writes
        send1(3'b001, 32'h11111111, 32'h22222222, 1, 32'h11111111, 32'h22222222, ka);
        send1(3'b010, 32'hAAAAAAAA, 32'h0,        1, 32'hAAAAAAAA, 32'h22222222, ka);
        send1(3'b011, 32'h0,        32'h55555555, 1, 32'hAAAAAAAA, 32'h55555555, ka);

        // NOP and reserved: no change, no done
        send1(3'b000, 32'h1234, 32'h5678, 0, 32'h0, 32'h0, ka);
        send1(3'b111, 32'h1234, 32'h5678, 0, 32'h0, 32'h0, ka);
        @(negedge clk);
        check("nop_hold", {hi1_o, lo1_o}, {32'hAAAAAAAA, 32'h55555555});

        // Carry across halves, with a WRITE held during busy
        send1(3'b001, 32'h00000001, 32'hFFFFFFFF, 1, 32'h00000001, 32'hFFFFFFFF, ka);
        send1(3'b100, 32'h0, 32'h1, 1, 32'h00000002, 32'h00000000, ka);
        check("madd_lo_first", {hi1_o, lo1_o}, {32'h1, 32'h0});
        check("madd_busy", {62'd0, busy1, rdy1}, 64'h2);
        send1(3'b001, 32'h3, 32'h4, 1, 32'h3, 32'h4, kb);
        check("held_accept_edge", 64'(kb - ka), 64'd2);

        // Borrow and wrap
        send1(3'b110, 32'h9, 32'h9, 1, 32'h0, 32'h0, ka);
        send1(3'b101, 32'h0, 32'h1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, ka);
        send1(3'b100, 32'h0, 32'h1, 1, 32'h0, 32'h0, ka);

        // Reset in the ACC_HI cycle
        send1(3'b001, 32'h5, 32'h6, 1, 32'h5, 32'h6, ka);
        send1(3'b100, 32'h0, 32'h1, 0, 32'h0, 32'h0, ka);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midop_reset", {hi1_o, lo1_o}, 64'd0);
        check("midop_flags", {61'd0, busy1, done1, rdy1}, 64'h1);
        repeat (3) @(negedge clk);

        // Single-cycle variant: back-to-back MADD
        send0(3'b001, 32'h0, 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFE);
        send0(3'b100, 32'h0, 32'h1, 32'h0, 32'hFFFFFFFF);
        send0(3'b100, 32'h0, 32'h1, 32'h1, 32'h0);
        send0(3'b100, 32'h0, 32'h1, 32'h1, 32'h1);
        send0(3'b101, 32'h0, 32'h2, 32'h0, 32'hFFFFFFFF);

        repeat (4) @(negedge clk);
        check("split_queue_drained", 64'(q1.size()), 64'd0);
        check("single_queue_drained", 64'(q0.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
